// File: rtl/led_frame_serializer_pkg.sv
// Shared definitions for the LED frame serializer: FSM state encoding and
// frame geometry (8 rows x 8 bits = 64 LEDs).
package led_frame_serializer_pkg;

    localparam int unsigned NLEDS = 64;
    localparam int unsigned NROWS = 8;
    localparam int unsigned ROW_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BIT_LO = 3'd1,
        BIT_HI = 3'd2,
        LATCH  = 3'd3,
        HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/led_frame_serializer_phase_timer.sv
// phase_timer: free-running phase counter that produces a tick on the last
// cycle of every CLK_DIV-cycle phase while run is high.
// Ports: clk, reset (sync, active-high), run (count enable, clears when low),
//        tick_c (combinational phase-end tick).
module phase_timer
    import led_frame_serializer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick_c
);

    localparam int unsigned PW = $clog2(CLK_DIV) + 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt;

    assign tick_c = run && (cnt == LAST);

    // Counter restarts from zero at every phase end and whenever idle.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/led_frame_serializer.sv
// led_frame_serializer: 8x8 frame buffer plus a serial transmitter that
// shifts the frame MSB-first (frame bit 63 down to 0) to an LED matrix
// driver, then pulses a latch strobe.
// Ports: clk, reset (sync, active-high), wr_en/wr_addr/wr_data (row write),
//        start (transfer request), ser_din/ser_dclk/ser_strobe (serial link),
//        busy (transfer in progress), done (one-cycle completion pulse).
module led_frame_serializer
    import led_frame_serializer_pkg::state_t;
    import led_frame_serializer_pkg::IDLE;
    import led_frame_serializer_pkg::BIT_LO;
    import led_frame_serializer_pkg::BIT_HI;
    import led_frame_serializer_pkg::LATCH;
    import led_frame_serializer_pkg::HOLD;
    import led_frame_serializer_pkg::NROWS;
    import led_frame_serializer_pkg::ROW_W;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned NLEDS   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       ser_din,
    output logic       ser_dclk,
    output logic       ser_strobe,
    output logic       busy,
    output logic       done
);

    // Packed so that the whole buffer reads as frame bits 63..0 directly.
    logic [NROWS-1:0][ROW_W-1:0] fbuf;
    logic [NLEDS-1:0]            shreg;
    logic [5:0]                  bit_cnt;
    state_t                      state;
    logic                        run_c;
    logic                        tick_c;

    assign run_c = (state != IDLE);

    phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .run   (run_c),
        .tick_c(tick_c)
    );

    // Frame buffer: writes land in any state; a same-cycle start snapshots
    // the old contents because the snapshot reads the registered value.
    always_ff @(posedge clk) begin
        if (reset) begin
            fbuf <= '0;
        end else if (wr_en) begin
            fbuf[wr_addr] <= wr_data;
        end
    end

    // Transfer FSM with registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            ser_din    <= 1'b0;
            ser_dclk   <= 1'b0;
            ser_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= BIT_LO;
                        shreg   <= NLEDS'(fbuf);
                        bit_cnt <= '0;
                        ser_din <= fbuf[NROWS-1][ROW_W-1];
                        busy    <= 1'b1;
                    end
                end
                BIT_LO: begin
                    if (tick_c) begin
                        state    <= BIT_HI;
                        ser_dclk <= 1'b1;
                    end
                end
                BIT_HI: begin
                    if (tick_c) begin
                        ser_dclk <= 1'b0;
                        if (bit_cnt == 6'(NLEDS - 1)) begin
                            state      <= LATCH;
                            ser_din    <= 1'b0;
                            ser_strobe <= 1'b1;
                        end else begin
                            // Next bit goes out together with the falling dclk.
                            state   <= BIT_LO;
                            bit_cnt <= bit_cnt + 6'd1;
                            shreg   <= {shreg[NLEDS-2:0], 1'b0};
                            ser_din <= shreg[NLEDS-2];
                        end
                    end
                end
                LATCH: begin
                    if (tick_c) begin
                        state      <= HOLD;
                        ser_strobe <= 1'b0;
                    end
                end
                HOLD: begin
                    if (tick_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Self-checking bench for led_frame_serializer: one instance with CLK_DIV=2
// and one with CLK_DIV=1, each observed by a receiver model.
module tb_led_frame_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic       start2 = 1'b0;
    logic       start1 = 1'b0;

    logic din2, dclk2, strobe2, busy2, done2;
    logic din1, dclk1, strobe1, busy1, done1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    led_frame_serializer #(.CLK_DIV(2), .NLEDS(64)) u_dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start2), .ser_din(din2), .ser_dclk(dclk2),
        .ser_strobe(strobe2), .busy(busy2), .done(done2)
    );

    led_frame_serializer #(.CLK_DIV(1), .NLEDS(64)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start1), .ser_din(din1), .ser_dclk(dclk1),
        .ser_strobe(strobe1), .busy(busy1), .done(done1)
    );

    // Receiver model and protocol monitor for the CLK_DIV=2 instance.
    int          rise2 = 0, strobes2 = 0, dones2 = 0, viol2 = 0, ones2 = 0;
    logic [63:0] chain2 = '0, vbuf2 = '0;
    logic        pdclk2 = 1'b0, pdin2 = 1'b0, pstrobe2 = 1'b0;

    always @(negedge clk) begin
        if (dclk2 && !pdclk2) begin
            rise2  <= rise2 + 1;
            ones2  <= ones2 + int'(din2);
            chain2 <= {chain2[62:0], din2};
        end
        if (strobe2 && !pstrobe2) begin
            strobes2 <= strobes2 + 1;
            vbuf2    <= chain2;
        end
        dones2 <= dones2 + int'(done2);
        viol2  <= viol2 + int'(dclk2 && (din2 !== pdin2)) + int'(strobe2 && dclk2)
                  + int'(!busy2 && (din2 || dclk2 || strobe2));
        pdclk2   <= dclk2;
        pdin2    <= din2;
        pstrobe2 <= strobe2;
    end

    // Receiver model and protocol monitor for the CLK_DIV=1 instance.
    int          rise1 = 0, strobes1 = 0, viol1 = 0;
    logic [63:0] chain1 = '0, vbuf1 = '0;
    logic        pdclk1 = 1'b0, pdin1 = 1'b0, pstrobe1 = 1'b0;

    always @(negedge clk) begin
        if (dclk1 && !pdclk1) begin
            rise1  <= rise1 + 1;
            chain1 <= {chain1[62:0], din1};
        end
        if (strobe1 && !pstrobe1) begin
            strobes1 <= strobes1 + 1;
            vbuf1    <= chain1;
        end
        viol1 <= viol1 + int'(dclk1 && (din1 !== pdin1)) + int'(strobe1 && dclk1)
                 + int'(!busy1 && (din1 || dclk1 || strobe1));
        pdclk1   <= dclk1;
        pdin1    <= din1;
        pstrobe1 <= strobe1;
    end

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_row(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic fill_rows(input logic [7:0] d);
        for (int r = 0; r < 8; r++) write_row(3'(r), d);
    endtask

    task automatic pulse_start2();
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
    endtask

    task automatic test_reset();
        int r0, s0, o0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        write_row(3'd5, 8'hFF);
        @(negedge clk); reset = 1'b1;
        // Write and start presented during reset must be ignored.
        @(negedge clk); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h0F; start2 = 1'b1; start1 = 1'b1;
        @(negedge clk); wr_en = 1'b0; start2 = 1'b0; start1 = 1'b0;
        @(negedge clk); reset = 1'b0;
        checks++; if (din2 !== 1'b0) $display("FAIL reset_din: got %0b want 0", din2); else passes++;
        checks++; if (dclk2 !== 1'b0) $display("FAIL reset_dclk: got %0b want 0", dclk2); else passes++;
        checks++; if (strobe2 !== 1'b0) $display("FAIL reset_strobe: got %0b want 0", strobe2); else passes++;
        checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy2); else passes++;
        checks++; if (done2 !== 1'b0) $display("FAIL reset_done: got %0b want 0", done2); else passes++;
        checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy_div1: got %0b want 0", busy1); else passes++;
        r0 = rise2; s0 = strobes2; o0 = ones2;
        pulse_start2();
        run_cycles(600);
        checks++; if (rise2 - r0 !== 64) $display("FAIL zero_frame_dclk: got %0d want 64", rise2 - r0); else passes++;
        checks++; if (strobes2 - s0 !== 1) $display("FAIL zero_frame_strobe: got %0d want 1", strobes2 - s0); else passes++;
        checks++; if (ones2 - o0 !== 0) $display("FAIL zero_frame_ones: got %0d want 0", ones2 - o0); else passes++;
        checks++; if (vbuf2 !== 64'h0) $display("FAIL zero_frame_vbuf: got %h want 0", vbuf2); else passes++;
    endtask

    task automatic test_frame_walk();
        int r0, s0, busy_cnt, done_at;
        for (int r = 0; r < 8; r++) write_row(3'(r), 8'(1 << r));
        r0 = rise2; s0 = strobes2; busy_cnt = 0; done_at = -1;
        @(negedge clk); start2 = 1'b1;
        // i counts rising edges starting with the accepting edge.
        for (int i = 1; i <= 600; i++) begin
            @(posedge clk); #1;
            if (i == 1) start2 = 1'b0;
            if (busy2) busy_cnt++;
            if (done2 && done_at < 0) done_at = i;
        end
        @(negedge clk);
        checks++; if (done_at !== 261) $display("FAIL walk_done_latency: got %0d want 261", done_at); else passes++;
        checks++; if (busy_cnt !== 260) $display("FAIL walk_busy_cycles: got %0d want 260", busy_cnt); else passes++;
        checks++; if (rise2 - r0 !== 64) $display("FAIL walk_dclk: got %0d want 64", rise2 - r0); else passes++;
        checks++; if (strobes2 - s0 !== 1) $display("FAIL walk_strobe: got %0d want 1", strobes2 - s0); else passes++;
        checks++; if (vbuf2[63] !== 1'b1) $display("FAIL walk_first_bit: got %0b want 1", vbuf2[63]); else passes++;
        checks++; if (vbuf2 !== 64'h8040_2010_0804_0201) $display("FAIL walk_vbuf: got %h want 8040201008040201", vbuf2); else passes++;
    endtask

    task automatic test_clkdiv1();
        int r0, busy_cnt, done_at;
        fill_rows(8'hAA);
        r0 = rise1; busy_cnt = 0; done_at = -1;
        @(negedge clk); start1 = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (i == 1) start1 = 1'b0;
            if (busy1) busy_cnt++;
            if (done1 && done_at < 0) done_at = i;
        end
        @(negedge clk);
        checks++; if (busy_cnt !== 130) $display("FAIL div1_busy_cycles: got %0d want 130", busy_cnt); else passes++;
        checks++; if (done_at !== 131) $display("FAIL div1_done_latency: got %0d want 131", done_at); else passes++;
        checks++; if (rise1 - r0 !== 64) $display("FAIL div1_dclk: got %0d want 64", rise1 - r0); else passes++;
        checks++; if (vbuf1[63:62] !== 2'b10) $display("FAIL div1_first_bits: got %b want 10", vbuf1[63:62]); else passes++;
        checks++; if (vbuf1 !== 64'hAAAA_AAAA_AAAA_AAAA) $display("FAIL div1_vbuf: got %h want aaaaaaaaaaaaaaaa", vbuf1); else passes++;
    endtask

    task automatic test_start_ignored();
        int r0, s0, d0;
        r0 = rise2; s0 = strobes2; d0 = dones2;
        pulse_start2();
        run_cycles(40);  pulse_start2();
        run_cycles(100); pulse_start2();
        run_cycles(100); pulse_start2();
        run_cycles(400);
        checks++; if (dones2 - d0 !== 1) $display("FAIL busy_start_done: got %0d want 1", dones2 - d0); else passes++;
        checks++; if (rise2 - r0 !== 64) $display("FAIL busy_start_dclk: got %0d want 64", rise2 - r0); else passes++;
        checks++; if (strobes2 - s0 !== 1) $display("FAIL busy_start_strobe: got %0d want 1", strobes2 - s0); else passes++;
        checks++; if (busy2 !== 1'b0) $display("FAIL busy_start_idle: got %0b want 0", busy2); else passes++;
        checks++; if (vbuf2 !== 64'hAAAA_AAAA_AAAA_AAAA) $display("FAIL busy_start_vbuf: got %h want aaaaaaaaaaaaaaaa", vbuf2); else passes++;
    endtask

    task automatic test_write_during();
        fill_rows(8'h00);
        pulse_start2();
        run_cycles(30);
        write_row(3'd3, 8'hFF);
        run_cycles(600);
        checks++; if (vbuf2 !== 64'h0) $display("FAIL wr_during_vbuf: got %h want 0", vbuf2); else passes++;
        // Write in the accepting cycle must not reach this frame.
        @(negedge clk); start2 = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55;
        @(negedge clk); start2 = 1'b0; wr_en = 1'b0;
        run_cycles(600);
        checks++; if (vbuf2 !== 64'h0000_0000_FF00_0000) $display("FAIL wr_next_vbuf: got %h want 00000000ff000000", vbuf2); else passes++;
        pulse_start2();
        run_cycles(600);
        checks++; if (vbuf2 !== 64'h0000_0000_FF00_0055) $display("FAIL wr_same_cycle_vbuf: got %h want 00000000ff000055", vbuf2); else passes++;
    endtask

    task automatic test_reset_mid();
        int r0, s0, d0;
        logic [63:0] saved;
        fill_rows(8'hFF);
        saved = vbuf2; r0 = rise2; s0 = strobes2; d0 = dones2;
        pulse_start2();
        for (int i = 0; i < 1000 && (rise2 - r0) < 20; i++) @(negedge clk);
        checks++; if (rise2 - r0 !== 20) $display("FAIL mid_reach_20: got %0d want 20", rise2 - r0); else passes++;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({din2, dclk2, strobe2, busy2, done2} !== 5'b0)
            $display("FAIL mid_reset_outputs: got %b want 00000", {din2, dclk2, strobe2, busy2, done2}); else passes++;
        @(negedge clk); reset = 1'b0;
        run_cycles(600);
        checks++; if (strobes2 - s0 !== 0) $display("FAIL mid_no_strobe: got %0d want 0", strobes2 - s0); else passes++;
        checks++; if (dones2 - d0 !== 0) $display("FAIL mid_no_done: got %0d want 0", dones2 - d0); else passes++;
        checks++; if (rise2 - r0 !== 20) $display("FAIL mid_dclk_total: got %0d want 20", rise2 - r0); else passes++;
        checks++; if (vbuf2 !== saved) $display("FAIL mid_vbuf_kept: got %h want %h", vbuf2, saved); else passes++;
    endtask

    task automatic test_protocol();
        checks++; if (viol2 !== 0) $display("FAIL protocol_div2: got %0d violations want 0", viol2); else passes++;
        checks++; if (viol1 !== 0) $display("FAIL protocol_div1: got %0d violations want 0", viol1); else passes++;
    endtask

    initial begin
        test_reset();
        test_frame_walk();
        test_clkdiv1();
        test_start_ignored();
        test_write_during();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/led_frame_serializer.md
LED_FRAME_SERIALIZER -- requirements
Module: led_frame_serializer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving clk cycles per half-period of ser_dclk (legal range 1..255).
REQ-002 The block SHALL have parameter NLEDS, default 64, giving frame bits per transfer (fixed 8 rows x 8 bits).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  frame-buffer write strobe, one row per cycle.
REQ-006 wr_addr  input  3  row index 0..7.
REQ-007 wr_data  input  8  row data; bit b of row r is frame bit r*8+b.
REQ-008 start  input  1  single-cycle request to transmit the current frame.
REQ-009 ser_din  output  1  serial data to the matrix driver.
REQ-010 ser_dclk  output  1  serial data clock; receiver samples ser_din on its rising edge.
REQ-011 ser_strobe  output  1  latch pulse; receiver copies its shift chain to the display on its rising edge.
REQ-012 busy  output  1  high while a transfer is in progress.
REQ-013 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-014 The block SHALL hold an 8x8-bit frame buffer; wr_en=1 writes wr_data to row wr_addr at the clock edge, in any state.
REQ-015 start SHALL be accepted only in IDLE; the full 64-bit frame SHALL be snapshotted into a shift register on the accepting edge; start while busy SHALL be ignored.
REQ-016 A write and an accepted start in the same cycle SHALL snapshot the pre-write row value; the write lands in the buffer for the next frame.
REQ-017 FSM states SHALL be IDLE, BIT_LO, BIT_HI, LATCH, HOLD.
REQ-018 BIT_LO: ser_dclk=0, ser_din = current bit, for CLK_DIV cycles, then BIT_HI.
REQ-019 BIT_HI: ser_dclk=1, ser_din unchanged, for CLK_DIV cycles; then BIT_LO with next bit, or LATCH after bit 64.
REQ-020 Bits SHALL be sent from frame bit 63 down to frame bit 0, so that after 64 receiver shifts chain position j holds frame bit j.
REQ-021 LATCH: ser_strobe=1, ser_dclk=0, for CLK_DIV cycles; then HOLD.
REQ-022 HOLD: ser_strobe=0, ser_dclk=0, for CLK_DIV cycles; then IDLE with done=1 for exactly that one cycle.
REQ-023 busy SHALL be 1 from the cycle after acceptance for exactly 130*CLK_DIV cycles, and SHALL fall in the same cycle done rises.
REQ-024 ser_din SHALL change only while ser_dclk=0 and never in the same cycle ser_dclk rises.
REQ-025 ser_strobe SHALL never be high while ser_dclk is high.
REQ-026 The phase counter SHALL be $clog2(CLK_DIV)+1 bits and wrap at CLK_DIV-1; the bit counter SHALL be 6 bits with terminal count 63, no overflow.
REQ-027 In IDLE, ser_din, ser_dclk and ser_strobe SHALL be 0.

Reset
REQ-028 reset=1 SHALL, at the next edge, force IDLE, all outputs 0, both counters 0, shift register and frame buffer all 0.
REQ-029 Reset mid-transfer SHALL abort with no ser_strobe pulse and no done pulse.
REQ-030 reset SHALL take priority over wr_en and start in the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, NLEDS=64, NROWS=8 and ROW_W=8.
REQ-032 One sub-module, phase_timer, SHALL generate the CLK_DIV phase-end tick; the FSM, frame buffer and shift register SHALL remain in the top module.

Verification
REQ-033 Assert reset 3 cycles -> ser_din/ser_dclk/ser_strobe/busy/done all 0; start then sends an all-zero frame.
REQ-034 Write rows 0..7 = 0x01,0x02,0x04,...,0x80, start, CLK_DIV=2 -> 64 ser_dclk rising edges with first sampled bit = 1 (row7 bit7); receiver model vbuf equals the written frame after ser_strobe; done exactly 261 cycles after the start edge.
REQ-035 CLK_DIV=1, frame 0xAA in every row -> busy high exactly 130 cycles; ser_din alternates 1,0,... from bit 63.
REQ-036 Pulse start 3 more times mid-transfer -> one done pulse, 64 dclk edges, 1 strobe.
REQ-037 Write row 3 = 0xFF during transfer of an all-zero frame -> that frame latches all 0; next start latches row 3 = 0xFF.
REQ-038 Assert reset after the 20th ser_dclk rising edge -> outputs 0 at next edge, no strobe, no done; receiver vbuf unchanged.
